// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared types and constants for the front-end stall/kill sequencer.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
package pipeline_ctrl_unit_pkg;

  localparam int PCTRL_STATE_WIDTH = 2;
  localparam int PCTRL_CNT_W = 3;
  localparam int PCTRL_NUM_RS = 4;
  localparam logic [31:0] PCTRL_TRAP_VEC = 32'h0000_0100;

  typedef enum logic [PCTRL_STATE_WIDTH-1:0] {
    PCTRL_RUN        = 2'd0,
    PCTRL_FLUSH      = 2'd1,
    PCTRL_TRAP_DRAIN = 2'd2,
    PCTRL_TRAP_REDIR = 2'd3
  } pctrl_state_e;

  // Select field must encode 0 (none) plus one code per RS.
  function automatic int sel_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_unit_if.sv
// Front-end control bundle: dispatch/ROB/execute inputs and
// stage stall/kill/redirect outputs of the sequencer.
interface pipeline_ctrl_unit_if
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int NUM_RS = PCTRL_NUM_RS
);
  localparam int SEL_W = sel_w(NUM_RS);

  logic             dp_valid_i;
  logic [SEL_W-1:0] dp_rs_ent_i;
  logic             dp_illegal_i;
  logic [NUM_RS-1:0] rs_full_i;
  logic             rob_full_i;
  logic             rob_empty_i;
  logic             mispredict_i;
  logic [31:0]      mispredict_pc_i;

  logic             stall_IF_o;
  logic             stall_ID_o;
  logic             stall_DP_o;
  logic             kill_IF_o;
  logic             kill_ID_o;
  logic             kill_DP_o;
  logic             redirect_valid_o;
  logic [31:0]      redirect_pc_o;
  logic [PCTRL_STATE_WIDTH-1:0] state_o;

  modport master (
    output dp_valid_i, dp_rs_ent_i, dp_illegal_i,
    output rs_full_i, rob_full_i, rob_empty_i,
    output mispredict_i, mispredict_pc_i,
    input  stall_IF_o, stall_ID_o, stall_DP_o,
    input  kill_IF_o, kill_ID_o, kill_DP_o,
    input  redirect_valid_o, redirect_pc_o, state_o
  );

  modport slave (
    input  dp_valid_i, dp_rs_ent_i, dp_illegal_i,
    input  rs_full_i, rob_full_i, rob_empty_i,
    input  mispredict_i, mispredict_pc_i,
    output stall_IF_o, stall_ID_o, stall_DP_o,
    output kill_IF_o, kill_ID_o, kill_DP_o,
    output redirect_valid_o, redirect_pc_o, state_o
  );

endinterface

// File: rtl/pipeline_hazard_detect.sv
// Structural hazard for one DP slot: target RS full or ROB full.
module pipeline_hazard_detect
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int NUM_RS = PCTRL_NUM_RS,
  localparam int SEL_W = sel_w(NUM_RS)
) (
  input  logic              dp_valid_i,
  input  logic [SEL_W-1:0]  dp_rs_ent_i,
  input  logic [NUM_RS-1:0] rs_full_i,
  input  logic              rob_full_i,
  output logic              hz_o
);

  logic rs_hit;

  // Select 0 and out-of-range selects never match.
  always_comb begin
    rs_hit = 1'b0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (dp_rs_ent_i == SEL_W'(k + 1)) rs_hit = rs_full_i[k];
    end
  end

  assign hz_o = dp_valid_i & (rs_hit | rob_full_i);

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Stall/kill sequencer for IF/ID/DP with mispredict and trap redirect.
// Define PIPE_CTRL_PERF_EN to add saturating perf counter ports.
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter int          NUM_RS       = PCTRL_NUM_RS,
  parameter logic [31:0] TRAP_VEC     = PCTRL_TRAP_VEC
) (
  input  logic clk_i,
  input  logic reset_i,
  pipeline_ctrl_unit_if.slave bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles_o,
  output logic [31:0] perf_flush_count_o,
  output logic [31:0] perf_trap_count_o
`endif
);

  localparam logic [PCTRL_CNT_W-1:0] FC =
    PCTRL_CNT_W'(FLUSH_CYCLES);

  pctrl_state_e           state_q, state_d;
  logic [PCTRL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   rv_q, rv_d;
  logic [31:0]            rpc_q, rpc_d;
  logic                   hz;
  logic                   trap_in;

  pipeline_hazard_detect #(
    .NUM_RS (NUM_RS)
  ) u_hz (
    .dp_valid_i  (bus.dp_valid_i),
    .dp_rs_ent_i (bus.dp_rs_ent_i),
    .rs_full_i   (bus.rs_full_i),
    .rob_full_i  (bus.rob_full_i),
    .hz_o        (hz)
  );

  assign trap_in = bus.dp_valid_i & bus.dp_illegal_i;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= PCTRL_RUN;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
    end
  end

  // Mispredict preempts every state and always reloads the flush.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rv_d    = 1'b0;
    rpc_d   = rpc_q;
    if (bus.mispredict_i) begin
      state_d = PCTRL_FLUSH;
      cnt_d   = FC;
      rv_d    = 1'b1;
      rpc_d   = bus.mispredict_pc_i;
    end else begin
      unique case (state_q)
        PCTRL_RUN: begin
          if (trap_in) state_d = PCTRL_TRAP_DRAIN;
        end
        PCTRL_FLUSH: begin
          if (cnt_q <= PCTRL_CNT_W'(1)) begin
            state_d = PCTRL_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - PCTRL_CNT_W'(1);
          end
        end
        PCTRL_TRAP_DRAIN: begin
          if (bus.rob_empty_i) state_d = PCTRL_TRAP_REDIR;
        end
        PCTRL_TRAP_REDIR: begin
          state_d = PCTRL_FLUSH;
          cnt_d   = FC;
          rv_d    = 1'b1;
          rpc_d   = TRAP_VEC;
        end
        default: state_d = PCTRL_RUN;
      endcase
    end
  end

  always_comb begin
    bus.stall_IF_o = 1'b0;
    bus.stall_ID_o = 1'b0;
    bus.stall_DP_o = 1'b0;
    bus.kill_IF_o  = 1'b0;
    bus.kill_ID_o  = 1'b0;
    bus.kill_DP_o  = 1'b0;
    unique case (1'b1)
      state_q == PCTRL_RUN: begin
        bus.stall_IF_o = hz & reset_i;
        bus.stall_ID_o = hz & reset_i;
        bus.stall_DP_o = hz & reset_i;
      end
      state_q == PCTRL_FLUSH: begin
        bus.kill_IF_o = 1'b1;
        bus.kill_ID_o = 1'b1;
        bus.kill_DP_o = 1'b1;
      end
      // Hold the front end while the illegal op is squashed in DP.
      state_q == PCTRL_TRAP_DRAIN,
      state_q == PCTRL_TRAP_REDIR: begin
        bus.stall_IF_o = 1'b1;
        bus.stall_ID_o = 1'b1;
        bus.kill_DP_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.redirect_valid_o = rv_q;
  assign bus.redirect_pc_o    = rpc_q;
  assign bus.state_o          = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] pst_q, pfl_q, ptr_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pst_q <= '0;
      pfl_q <= '0;
      ptr_q <= '0;
    end else begin
      if (state_q == PCTRL_RUN && hz) pst_q <= sat_inc(pst_q);
      if (bus.mispredict_i) pfl_q <= sat_inc(pfl_q);
      if (state_q == PCTRL_RUN && !bus.mispredict_i && trap_in)
        ptr_q <= sat_inc(ptr_q);
    end
  end

  assign perf_stall_cycles_o = pst_q;
  assign perf_flush_count_o  = pfl_q;
  assign perf_trap_count_o   = ptr_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit (FLUSH_CYCLES=2).
module tb_pipeline_ctrl_unit;
  import pipeline_ctrl_unit_pkg::*;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk_i = ~clk_i;

  pipeline_ctrl_unit_if bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_st, perf_fl, perf_tr;
`endif

  pipeline_ctrl_unit dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles_o (perf_st),
    .perf_flush_count_o  (perf_fl),
    .perf_trap_count_o   (perf_tr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // {stall_IF, stall_ID, stall_DP, kill_IF, kill_ID, kill_DP}
  task automatic chk_ctl(input string tag, input logic [5:0] exp);
    chk(tag, {26'd0, bus.stall_IF_o, bus.stall_ID_o, bus.stall_DP_o,
              bus.kill_IF_o, bus.kill_ID_o, bus.kill_DP_o}, {26'd0, exp});
  endtask

  task automatic chk_st(input string tag, input logic [1:0] exp);
    chk(tag, {30'd0, bus.state_o}, {30'd0, exp});
  endtask

  task automatic chk_rd(input string tag, input logic v,
                        input logic [31:0] pc);
    chk({tag, "_v"}, {31'd0, bus.redirect_valid_o}, {31'd0, v});
    chk({tag, "_pc"}, bus.redirect_pc_o, pc);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.dp_valid_i      = 1'b1;
    bus.dp_rs_ent_i     = 3'd2;
    bus.dp_illegal_i    = 1'b0;
    bus.rs_full_i       = 4'b0010;
    bus.rob_full_i      = 1'b0;
    bus.rob_empty_i     = 1'b0;
    bus.mispredict_i    = 1'b0;
    bus.mispredict_pc_i = 32'h0;

    // Reset with a hazard present: stalls must stay low.
    cyc(); cyc(); #1;
    chk_ctl("rst_ctl", 6'b000000);
    chk_st("rst_state", 2'd0);
    chk_rd("rst_rd", 1'b0, 32'h0);
    reset_i = 1'b1;
    #1;
    chk_ctl("hz_rs2", 6'b111000);

    // Hazard clears next cycle.
    cyc(); bus.rs_full_i = 4'b0000; #1;
    chk_ctl("hz_clear", 6'b000000);

    // Selector boundaries.
    bus.rs_full_i = 4'b1111; bus.dp_rs_ent_i = 3'd5; #1;
    chk_ctl("hz_sel5", 6'b000000);
    bus.dp_rs_ent_i = 3'd0; #1;
    chk_ctl("hz_sel0", 6'b000000);
    bus.rs_full_i = 4'b1000; bus.dp_rs_ent_i = 3'd4; #1;
    chk_ctl("hz_sel4", 6'b111000);
    bus.rs_full_i = 4'b0000; bus.rob_full_i = 1'b1; #1;
    chk_ctl("hz_rob", 6'b111000);
    bus.dp_valid_i = 1'b0; #1;
    chk_ctl("hz_novalid", 6'b000000);

    // Mispredict with simultaneous hazard.
    cyc();
    bus.dp_valid_i = 1'b1;
    bus.mispredict_i = 1'b1;
    bus.mispredict_pc_i = 32'h8000_0040;
    #1;
    chk_ctl("mp_hz", 6'b111000);
    cyc(); bus.mispredict_i = 1'b0; #1;
    chk_ctl("fl1_ctl", 6'b000111);
    chk_st("fl1_st", 2'd1);
    chk_rd("fl1_rd", 1'b1, 32'h8000_0040);
    cyc(); bus.dp_valid_i = 1'b0; bus.rob_full_i = 1'b0; #1;
    chk_ctl("fl2_ctl", 6'b000111);
    chk_rd("fl2_rd", 1'b0, 32'h8000_0040);
    cyc(); #1;
    chk_st("fl_done", 2'd0);
    chk_ctl("fl_done_ctl", 6'b000000);

    // Trap with 5-cycle drain.
    cyc(); bus.dp_valid_i = 1'b1; bus.dp_illegal_i = 1'b1; #1;
    chk_st("tr_run", 2'd0);
    cyc(); bus.dp_valid_i = 1'b0; bus.dp_illegal_i = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk_st("tr_drain", 2'd2);
      chk_ctl("tr_drain_ctl", 6'b110001);
      cyc(); #1;
    end
    bus.rob_empty_i = 1'b1; #1;
    chk_st("tr_drain_last", 2'd2);
    cyc(); bus.rob_empty_i = 1'b0; #1;
    chk_st("tr_redir", 2'd3);
    chk_rd("tr_redir_rd", 1'b0, 32'h8000_0040);
    cyc(); #1;
    chk_st("tr_fl1", 2'd1);
    chk_rd("tr_fl1_rd", 1'b1, 32'h0000_0100);
    chk_ctl("tr_fl1_ctl", 6'b000111);
    cyc(); #1;
    chk_ctl("tr_fl2_ctl", 6'b000111);
    chk_rd("tr_fl2_rd", 1'b0, 32'h0000_0100);
    cyc(); #1;
    chk_st("tr_done", 2'd0);

    // Mispredict aborts a draining trap.
    bus.dp_valid_i = 1'b1; bus.dp_illegal_i = 1'b1; #1;
    cyc(); bus.dp_valid_i = 1'b0; bus.dp_illegal_i = 1'b0; #1;
    chk_st("ab_drain", 2'd2);
    cyc(); bus.mispredict_i = 1'b1; bus.mispredict_pc_i = 32'h2000; #1;
    cyc(); bus.mispredict_i = 1'b0; #1;
    chk_st("ab_fl", 2'd1);
    chk_rd("ab_rd", 1'b1, 32'h2000);
    cyc(); cyc(); #1;
    chk_st("ab_done", 2'd0);
    chk_rd("ab_done_rd", 1'b0, 32'h2000);

    // Second mispredict at flush count 1 extends the flush.
    bus.mispredict_i = 1'b1; bus.mispredict_pc_i = 32'h1111_0000; #1;
    cyc(); bus.mispredict_i = 1'b0; #1;
    cyc(); bus.mispredict_i = 1'b1; bus.mispredict_pc_i = 32'h3000; #1;
    chk_st("re_cnt1", 2'd1);
    cyc(); bus.mispredict_i = 1'b0; #1;
    chk_rd("re_rd", 1'b1, 32'h3000);
    chk_ctl("re_k1", 6'b000111);
    cyc(); #1;
    chk_ctl("re_k2", 6'b000111);
    cyc(); #1;
    chk_st("re_done", 2'd0);

    // ROB already empty, mispredict lands in TRAP_REDIR.
    bus.dp_valid_i = 1'b1; bus.dp_illegal_i = 1'b1;
    bus.rob_empty_i = 1'b1; #1;
    cyc(); bus.dp_valid_i = 1'b0; bus.dp_illegal_i = 1'b0; #1;
    chk_st("fe_drain", 2'd2);
    cyc(); bus.mispredict_i = 1'b1; bus.mispredict_pc_i = 32'h4000; #1;
    chk_st("fe_redir", 2'd3);
    cyc(); bus.mispredict_i = 1'b0; bus.rob_empty_i = 1'b0; #1;
    chk_rd("fe_rd", 1'b1, 32'h4000);
    cyc(); cyc(); #1;
    chk_st("fe_done", 2'd0);

    // Reset mid-flush.
    bus.mispredict_i = 1'b1; bus.mispredict_pc_i = 32'h5000; #1;
    cyc(); bus.mispredict_i = 1'b0; #1;
    chk_st("rf_fl", 2'd1);
    reset_i = 1'b0; #1;
    chk_ctl("rf_ctl", 6'b000000);
    chk_st("rf_st", 2'd0);
    chk_rd("rf_rd", 1'b0, 32'h0);
    cyc(); reset_i = 1'b1; #1;
    chk_st("rf_rel_st", 2'd0);
    cyc(); #1;
    chk_rd("rf_rel_rd", 1'b0, 32'h0);
    chk_ctl("rf_rel_ctl", 6'b000000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
